// File: rtl/ex_mem_pipe_if.sv
// EX -> MEM stage bus: EX-side operands in, registered MEM-side fields and
// multi-cycle accumulate feedback out.
interface ex_mem_pipe_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned ALUOP_W = 8,
   parameter int unsigned CNT_W   = 2
);
   // EX-side operands
   logic [RADDR_W-1:0]  ex_wd;
   logic                ex_wreg;
   logic [DATA_W-1:0]   ex_wdata;
   logic [DATA_W-1:0]   ex_hi;
   logic [DATA_W-1:0]   ex_lo;
   logic                ex_whilo;
   logic [ALUOP_W-1:0]  ex_aluop;
   logic [DATA_W-1:0]   ex_mem_addr;
   logic [DATA_W-1:0]   ex_reg2;
   logic [2*DATA_W-1:0] hilo_temp_i;
   logic [CNT_W-1:0]    cnt_i;

   // MEM-side registered fields
   logic [RADDR_W-1:0]  mem_wd;
   logic                mem_wreg;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_hi;
   logic [DATA_W-1:0]   mem_lo;
   logic                mem_whilo;
   logic [ALUOP_W-1:0]  mem_aluop;
   logic [DATA_W-1:0]   mem_mem_addr;
   logic [DATA_W-1:0]   mem_reg2;
   logic                mem_valid;
   logic [2*DATA_W-1:0] hilo_temp_o;
   logic [CNT_W-1:0]    cnt_o;

   // Execute stage drives operands and consumes the feedback
   modport master (
      output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
             ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
      input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
             mem_mem_addr, mem_reg2, mem_valid, hilo_temp_o, cnt_o
   );

   // Pipeline register consumes operands and drives the stage outputs
   modport slave (
      input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
             ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
      output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
             mem_mem_addr, mem_reg2, mem_valid, hilo_temp_o, cnt_o
   );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with hold, bubble insertion, flush, multi-cycle
// accumulate feedback to EX and a saturating bubble counter.
module ex_mem_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned ALUOP_W = 8,
   parameter int unsigned STALL_W = 6,
   parameter int unsigned EX_IDX  = 2,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned PERF_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   ex_mem_pipe_if.slave       bus,
   output logic [PERF_W-1:0]  bubble_cnt
);

   localparam int unsigned MEM_IDX = EX_IDX + 1;

   logic ex_stall;
   logic mem_stall;
   logic do_flush;
   logic do_bubble;
   logic do_adv;

   // Only the EX and MEM bits matter; the rest of the vector is deliberately ignored
   logic unused_stall;
   assign unused_stall = ^stall;

   assign ex_stall  = stall[EX_IDX];
   assign mem_stall = stall[MEM_IDX];

   // Edge action decode; EX running with MEM stalled cannot occur and falls into advance
   assign do_flush  = flush;
   assign do_bubble = !flush && ex_stall && !mem_stall;
   assign do_adv    = !flush && !ex_stall;

   // Stage register: bubble on flush/bubble, capture EX on advance, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_wd       <= '0;
         bus.mem_wreg     <= 1'b0;
         bus.mem_wdata    <= '0;
         bus.mem_hi       <= '0;
         bus.mem_lo       <= '0;
         bus.mem_whilo    <= 1'b0;
         bus.mem_aluop    <= '0;
         bus.mem_mem_addr <= '0;
         bus.mem_reg2     <= '0;
         bus.mem_valid    <= 1'b0;
         bus.hilo_temp_o  <= '0;
         bus.cnt_o        <= '0;
         bubble_cnt       <= '0;
      end else begin
         if (do_flush || do_bubble) begin
            bus.mem_wd       <= '0;
            bus.mem_wreg     <= 1'b0;
            bus.mem_wdata    <= '0;
            bus.mem_hi       <= '0;
            bus.mem_lo       <= '0;
            bus.mem_whilo    <= 1'b0;
            bus.mem_aluop    <= '0;
            bus.mem_mem_addr <= '0;
            bus.mem_reg2     <= '0;
            bus.mem_valid    <= 1'b0;
         end else if (do_adv) begin
            bus.mem_wd       <= bus.ex_wd;
            bus.mem_wreg     <= bus.ex_wreg;
            bus.mem_wdata    <= bus.ex_wdata;
            bus.mem_hi       <= bus.ex_hi;
            bus.mem_lo       <= bus.ex_lo;
            bus.mem_whilo    <= bus.ex_whilo;
            bus.mem_aluop    <= bus.ex_aluop;
            bus.mem_mem_addr <= bus.ex_mem_addr;
            bus.mem_reg2     <= bus.ex_reg2;
            bus.mem_valid    <= 1'b1;
         end

         // Accumulate state survives only while EX is stalled behind a bubble
         if (do_bubble) begin
            bus.hilo_temp_o <= bus.hilo_temp_i;
            bus.cnt_o       <= bus.cnt_i;
         end else if (do_flush || do_adv) begin
            bus.hilo_temp_o <= '0;
            bus.cnt_o       <= '0;
         end

         // Flushes are not counted as inserted bubbles
         if (do_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + PERF_W'(1);
         end
      end
   end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register between the execute and memory-access stages.
- Carries the GPR writeback, HI/LO writeback and load/store operands.
- Adds stall and flush handling: hold, bubble insertion and flush.
- Carries multi-cycle accumulate state (hilo_temp, cnt) back to EX while EX is stalled.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, width of data, HI, LO and address paths.
- RADDR_W, 5, register-file address width.
- ALUOP_W, 8, ALU opcode width forwarded to MEM.
- STALL_W, 6, width of the pipeline stall vector.
- EX_IDX, 2, bit of stall that stalls EX; bit EX_IDX+1 stalls MEM. Must satisfy EX_IDX+1 < STALL_W.
- CNT_W, 2, width of the multi-cycle op step counter.
- PERF_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  STALL_W  per-stage stall request from the stall controller.
- flush  in  1  synchronous kill of the EX/MEM contents (exception/eret).
- ex_wd  in  RADDR_W  destination GPR.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  DATA_W  GPR write data.
- ex_hi, ex_lo  in  DATA_W  HI/LO write data.
- ex_whilo  in  1  HI/LO write enable.
- ex_aluop  in  ALUOP_W  opcode for load/store decode in MEM.
- ex_mem_addr  in  DATA_W  effective address.
- ex_reg2  in  DATA_W  store data.
- hilo_temp_i  in  2*DATA_W  partial madd/msub product from EX.
- cnt_i  in  CNT_W  EX multi-cycle step.
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as the ex_ counterparts  registered stage outputs.
- mem_valid  out  1  stage holds a real instruction (not a bubble).
- hilo_temp_o  out  2*DATA_W  partial product fed back to EX.
- cnt_o  out  CNT_W  step fed back to EX.
- bubble_cnt  out  PERF_W  bubbles inserted since reset, saturating.

Behaviour:
- All state is registered on the rising edge of clk.
- Reset (rst=1, asynchronous, immediate): every output is 0. mem_wd is 0 (NOP register address) and mem_wreg, mem_whilo, mem_valid are all 0.
- Per-edge action, highest priority first:
  1. flush=1: load the bubble (all mem_* fields 0, mem_valid=0). hilo_temp_o=0, cnt_o=0. bubble_cnt unchanged.
  2. Bubble, when stall[EX_IDX]=1 and stall[EX_IDX+1]=0: load the bubble. hilo_temp_o<=hilo_temp_i, cnt_o<=cnt_i. bubble_cnt increments, saturating at all-ones.
  3. Hold, when stall[EX_IDX]=1 and stall[EX_IDX+1]=1: all registers keep their values.
  4. Advance, when stall[EX_IDX]=0: every mem_* field takes its ex_* counterpart, mem_valid<=1, hilo_temp_o<=0, cnt_o<=0.
- The case stall[EX_IDX]=0 with stall[EX_IDX+1]=1 is illegal (the controller never produces it). The block treats it as Advance.
- Latency is exactly one cycle from EX inputs to mem_* outputs; there is no combinational path from input to output.
- Stall bits other than EX_IDX and EX_IDX+1 are ignored.
- Reset asserted mid-operation clears everything, including bubble_cnt and an in-flight hilo_temp/cnt.
- Flush wins over any stall pattern.

Test Plan:
- Reset mid-stream: drive traffic, assert rst between edges -> all outputs 0 immediately, before the next edge. bubble_cnt=0.
- Advance: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF -> next edge: mem_wd=3, mem_wreg=1, mem_wdata=DEADBEEF, mem_valid=1, cnt_o=0.
- Bubble with madd carry: stall=6'b000111 (EX_IDX=2), hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=1 -> mem_wreg=0, mem_whilo=0, mem_valid=0, hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1, bubble_cnt=1. Next edge with stall=0 -> cnt_o=0, hilo_temp_o=0.
- Hold: load one instruction, then stall=6'b001111 for 3 cycles with changing ex_* -> mem_* outputs unchanged for all 3 cycles, bubble_cnt unchanged.
- Flush priority: stall=6'b000111 together with flush=1 -> bubble loaded, cnt_o=0, hilo_temp_o=0, bubble_cnt not incremented.
- Saturation: with PERF_W=4, apply 20 consecutive bubble cycles -> bubble_cnt stops at 4'hF.
